// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS controller:
// FSM states, opcode/funct encodings, ALU control codes and the control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       mem2reg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decode from the FSM's aluop and the R-type funct field.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// All control outputs are held at zero while RST is high.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       mem2reg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alu_control,
    output logic [3:0] state_o,
    output logic       instr_done,
    output logic       illegal
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_c, ctrl;
    logic [2:0] alu_control_raw;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl_c  = '0;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ctrl_c.irwrite = 1'b1;
                ctrl_c.pcwrite = 1'b1;
                ctrl_c.alusrcb = 2'b01;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl_c.alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d           = S_FETCH;
                        ctrl_c.instr_done = 1'b1;
                        ctrl_c.illegal    = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = 2'b10;
                state_d        = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl_c.iord = 1'b1;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_c.mem2reg    = 1'b1;
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.iord       = 1'b1;
                ctrl_c.memwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.aluop   = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.regdst     = 1'b1;
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alusrca    = 1'b1;
                ctrl_c.aluop      = ALUOP_SUB;
                ctrl_c.pcsrc      = 2'b01;
                ctrl_c.branch     = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = 2'b10;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pcsrc      = 2'b10;
                ctrl_c.pcwrite    = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (ctrl.aluop),
        .funct       (funct),
        .alu_control (alu_control_raw)
    );

    // Reset gates the control word combinationally so no write can leak out during reset.
    assign ctrl        = RST ? '0 : ctrl_c;
    assign alu_control = RST ? 3'b000 : alu_control_raw;

    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign memwrite   = ctrl.memwrite;
    assign regdst     = ctrl.regdst;
    assign mem2reg    = ctrl.mem2reg;
    assign regwrite   = ctrl.regwrite;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes the hand-derived expected control word per cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       mem2reg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluc;
        logic       done;
        logic       ill;
    } obs_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       iord, irwrite, memwrite, regdst, mem2reg, regwrite, alusrca, pcen, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    logic       iord0, irwrite0, memwrite0, regdst0, mem2reg0, regwrite0, alusrca0, pcen0, done0, ill0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] aluc0;
    logic [3:0] st0;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    mips_multicycle_ctrl dut (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
        .mem2reg(mem2reg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alu_control(alu_control),
        .state_o(state_o), .instr_done(instr_done), .illegal(illegal)
    );

    mips_multicycle_ctrl #(.TRAP_ILLEGAL(1'b0)) dut_notrap (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero),
        .iord(iord0), .irwrite(irwrite0), .memwrite(memwrite0), .regdst(regdst0),
        .mem2reg(mem2reg0), .regwrite(regwrite0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .pcen(pcen0), .alu_control(aluc0),
        .state_o(st0), .instr_done(done0), .illegal(ill0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-written expected control word for each state, with trap enabled.
    function automatic obs_t expect_st(input logic [3:0] st, input logic z,
                                       input logic [2:0] xal, input logic bad);
        obs_t e;
        e = '0;
        e.st   = st;
        e.aluc = 3'b010;
        case (st)
            4'd0: begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
            4'd1: begin e.alusrcb = 2'b11; e.done = bad; e.ill = bad; end
            4'd2: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd3: e.iord = 1;
            4'd4: begin e.mem2reg = 1; e.regwrite = 1; e.done = 1; end
            4'd5: begin e.iord = 1; e.memwrite = 1; e.done = 1; end
            4'd6: begin e.alusrca = 1; e.aluc = xal; end
            4'd7: begin e.regdst = 1; e.regwrite = 1; e.done = 1; end
            4'd8: begin e.alusrca = 1; e.pcsrc = 2'b01; e.pcen = z; e.aluc = 3'b110; e.done = 1; end
            4'd9: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd10: begin e.regwrite = 1; e.done = 1; end
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; e.done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t rst_exp(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic step(input obs_t e, input logic rst_v, input logic [5:0] op_v,
                        input logic [5:0] funct_v, input logic zero_v);
        @(posedge CLK);
        #1;
        RST   = rst_v;
        op    = op_v;
        funct = funct_v;
        zero  = zero_v;
        exp_q.push_back(e);
    endtask

    // seq holds the expected state of cycle i in nibble i.
    task automatic run(input logic [5:0] op_v, input logic [5:0] funct_v, input logic zero_v,
                       input logic [23:0] seq, input int n, input logic [2:0] xal, input logic bad);
        for (int i = 0; i < n; i++) begin
            step(expect_st(seq[4*i +: 4], zero_v, xal, bad), 1'b0, op_v, funct_v, zero_v);
        end
    endtask

    always @(negedge CLK) begin
        obs_t o, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = {state_o, iord, irwrite, memwrite, regdst, mem2reg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alu_control, instr_done, illegal};
            check($sformatf("ctrl_word_state%0d", e.st), 32'(o), 32'(e));
            check("notrap_state", 32'(st0), 32'(e.st));
            check("notrap_illegal", 32'(ill0), 32'd0);
        end
    end

    initial begin
        // Reset held across two edges; first edge puts the FSM in FETCH with outputs forced low.
        @(posedge CLK);
        #1;
        exp_q.push_back(rst_exp(4'd0));

        run(6'b100011, 6'd0, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, 3'b010, 1'b0);          // lw
        run(6'b101011, 6'd0, 1'b0, {4'd5, 4'd2, 4'd1, 4'd0}, 4, 3'b010, 1'b0);                // sw
        run(6'b000000, 6'b100010, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 3'b110, 1'b0);           // sub
        run(6'b000000, 6'b101010, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 3'b111, 1'b0);           // slt
        run(6'b000000, 6'b100100, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 3'b000, 1'b0);           // and
        run(6'b000000, 6'b100101, 1'b1, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 3'b001, 1'b0);           // or
        run(6'b000000, 6'b111111, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 3'b010, 1'b0);           // unknown funct
        run(6'b001000, 6'd0, 1'b0, {4'd10, 4'd9, 4'd1, 4'd0}, 4, 3'b010, 1'b0);               // addi
        run(6'b000100, 6'd0, 1'b1, {4'd8, 4'd1, 4'd0}, 3, 3'b010, 1'b0);                      // beq taken
        run(6'b000100, 6'd0, 1'b0, {4'd8, 4'd1, 4'd0}, 3, 3'b010, 1'b0);                      // beq not taken
        run(6'b000010, 6'd0, 1'b0, {4'd11, 4'd1, 4'd0}, 3, 3'b010, 1'b0);                     // j
        run(6'b111111, 6'd0, 1'b0, {4'd1, 4'd0}, 2, 3'b010, 1'b1);                            // illegal

        // lw abandoned by reset in MEMRD, then a jump must start cleanly from FETCH.
        run(6'b100011, 6'd0, 1'b0, {4'd2, 4'd1, 4'd0}, 3, 3'b010, 1'b0);
        step(rst_exp(4'd3), 1'b1, 6'b100011, 6'd0, 1'b0);
        step(rst_exp(4'd0), 1'b1, 6'b100011, 6'd0, 1'b0);
        run(6'b000010, 6'd0, 1'b0, {4'd11, 4'd1, 4'd0}, 3, 3'b010, 1'b0);
        run(6'b000000, 6'b100000, 1'b0, {4'd0}, 1, 3'b010, 1'b0);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
